// File: rtl/ni_rx.sv
// Receive-side network interface: router egress stream into a flit FIFO,
// drained by the processing element through a small AXI-lite register file.
module ni_rx #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MY_X       = 0,
  parameter int unsigned MY_Y       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [4:0]  awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [4:0]  araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        irq
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam logic [4:0] A_STATUS = 5'h00;
  localparam logic [4:0] A_DATA   = 5'h04;
  localparam logic [4:0] A_LAST   = 5'h08;
  localparam logic [4:0] A_CTRL   = 5'h0C;
  localparam logic [4:0] A_DROP   = 5'h10;
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  typedef enum logic [1:0] {HDR, BODY, DROP} state_e;

  state_e          state_q, state_d;
  logic [32:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d, pkt_cnt_q, pkt_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            en_q, en_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]     rdata_q, rdata_d, status_c;
  logic [32:0]     head_c;
  logic            empty_c, full_c, match_c, tready_c, hs_c, store_c, drop_c;
  logic            wr_fire_c, rd_fire_c, pop_c, flush_c;
  logic            unused_c;

  assign unused_c = ^{s_tdata[31:24], s_tdata[15:0], wdata[31:3], wstrb[3:1]};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    drop_c     = 1'b0;

    empty_c   = (level_q == '0);
    full_c    = (level_q == LW'(FIFO_DEPTH));
    head_c    = mem_q[rd_ptr_q];
    wr_fire_c = !rst && awvalid && wvalid && !bvalid_q;
    rd_fire_c = !rst && arvalid && !rvalid_q;
    pop_c     = rd_fire_c && (araddr == A_DATA) && !empty_c;
    flush_c   = wr_fire_c && (awaddr == A_CTRL) && wstrb[0] && wdata[2];
    match_c   = (s_tdata[23:20] == 4'(MY_X)) && (s_tdata[19:16] == 4'(MY_Y));

    // A pop in the same cycle frees the slot for an incoming flit
    tready_c = 1'b0;
    if (!rst && en_q) tready_c = (state_q == DROP) || !full_c || pop_c;
    hs_c    = s_tvalid && tready_c;
    store_c = hs_c && !flush_c && ((state_q == BODY) || ((state_q == HDR) && match_c));

    // A flush cuts any packet being stored; its remainder is discarded
    if (flush_c && ((state_q == BODY) || ((state_q == HDR) && hs_c && match_c))) begin
      drop_c  = 1'b1;
      state_d = (hs_c && s_tlast) ? HDR : DROP;
    end else if (hs_c) begin
      case (state_q)
        HDR: begin
          drop_c = !match_c;
          if (!s_tlast) state_d = match_c ? BODY : DROP;
        end
        BODY, DROP: if (s_tlast) state_d = HDR;
        default:    state_d = HDR;
      endcase
    end

    if (store_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)   rd_ptr_d = rd_ptr_q + AW'(1);
    level_d   = level_q + LW'(store_c) - LW'(pop_c);
    pkt_cnt_d = pkt_cnt_q + LW'(store_c && s_tlast) - LW'(pop_c && head_c[32]);
    if (flush_c) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      pkt_cnt_d = '0;
    end

    if (drop_c && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;

    if (wr_fire_c) begin
      bvalid_d = 1'b1;
      bresp_d  = OKAY;
      case (awaddr)
        A_CTRL: if (wstrb[0]) begin
          en_d     = wdata[0];
          irq_en_d = wdata[1];
        end
        A_DROP:                   drop_cnt_d = '0;
        A_STATUS, A_DATA, A_LAST: ;
        default:                  bresp_d = SLVERR;
      endcase
    end else if (bready) begin
      bvalid_d = 1'b0;
    end

    status_c = {8'h00, 8'(pkt_cnt_q), 8'(level_q), 5'h00, (pkt_cnt_q != '0), full_c, empty_c};
    if (rd_fire_c) begin
      rvalid_d = 1'b1;
      rresp_d  = OKAY;
      case (araddr)
        A_STATUS: rdata_d = status_c;
        A_DATA: begin
          rdata_d = empty_c ? 32'h0 : head_c[31:0];
          if (empty_c) rresp_d = SLVERR;
        end
        A_LAST:  rdata_d = {31'h0, !empty_c && head_c[32]};
        A_CTRL:  rdata_d = {30'h0, irq_en_q, en_q};
        A_DROP:  rdata_d = {16'h0, drop_cnt_q};
        default: begin
          rdata_d = 32'h0;
          rresp_d = SLVERR;
        end
      endcase
    end else if (rready) begin
      rvalid_d = 1'b0;
    end

    irq_d = irq_en_q && (pkt_cnt_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      en_q       <= 1'b1;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Flit storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (store_c) mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
  end

  assign s_tready = tready_c;
  assign awready  = wr_fire_c;
  assign wready   = wr_fire_c;
  assign arready  = !rst && !rvalid_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_ni_rx.sv
// Bench for ni_rx: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the receive interface.
module tb_ni_rx;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ni_rx #(.FIFO_DEPTH(DEPTH), .MY_X(0), .MY_Y(0)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue, packet count derived from its contents
  logic [32:0] mq[$];
  bit          m_in_pkt, m_keep, m_en, m_irq_en, m_irq, m_last_hs;
  int          m_drop;
  bit          m_bvalid, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;

  function automatic int m_pkts();
    int n = 0;
    foreach (mq[i]) if (mq[i][32]) n++;
    return n;
  endfunction

  function automatic bit m_pop_now();
    return arvalid && !m_rvalid && (araddr == 5'h04) && (mq.size() > 0);
  endfunction

  function automatic bit m_tready();
    if (!m_en) return 1'b0;
    if (m_in_pkt && !m_keep) return 1'b1;
    return (mq.size() < DEPTH) || m_pop_now();
  endfunction

  task automatic m_reset();
    mq.delete();
    m_in_pkt = 0; m_keep = 0; m_en = 1; m_irq_en = 0; m_irq = 0; m_last_hs = 0;
    m_drop = 0; m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
  endtask

  task automatic m_count_drop();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic m_edge();
    bit wr, rd, hs, pop, flush, match;
    int pk, sz;
    bit old_irq_en;
    wr = awvalid && wvalid && !m_bvalid;
    rd = arvalid && !m_rvalid;
    hs = s_tvalid && m_tready();
    pop = m_pop_now();
    pk = m_pkts();
    sz = mq.size();
    old_irq_en = m_irq_en;
    flush = wr && (awaddr == 5'h0C) && wstrb[0] && wdata[2];
    match = (s_tdata[23:16] == 8'h00);
    if (rd) begin
      m_rvalid = 1; m_rresp = 2'b00; m_rdata = 0;
      case (araddr)
        5'h00: m_rdata = {8'h00, 8'(pk), 8'(sz), 5'h00, pk != 0, sz == DEPTH, sz == 0};
        5'h04: if (sz == 0) m_rresp = 2'b10; else m_rdata = mq[0][31:0];
        5'h08: m_rdata = (sz != 0) ? {31'h0, mq[0][32]} : 32'h0;
        5'h0C: m_rdata = {30'h0, m_irq_en, m_en};
        5'h10: m_rdata = 32'(m_drop);
        default: m_rresp = 2'b10;
      endcase
    end else if (rready) m_rvalid = 0;
    if (pop) void'(mq.pop_front());
    if (hs) begin
      if (!m_in_pkt) begin
        if (match && !flush) mq.push_back({s_tlast, s_tdata});
        else m_count_drop();
        m_keep = match && !flush;
      end else if (m_keep) begin
        if (flush) begin m_count_drop(); m_keep = 0; end
        else mq.push_back({s_tlast, s_tdata});
      end
      m_in_pkt = !s_tlast;
    end else if (flush && m_in_pkt && m_keep) begin
      m_count_drop();
      m_keep = 0;
    end
    if (flush) mq.delete();
    if (wr) begin
      m_bvalid = 1;
      m_bresp = (awaddr inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10}) ? 2'b00 : 2'b10;
      if (awaddr == 5'h0C && wstrb[0]) begin m_en = wdata[0]; m_irq_en = wdata[1]; end
      if (awaddr == 5'h10) m_drop = 0;
    end else if (bready) m_bvalid = 0;
    m_irq = old_irq_en && (pk != 0);
    m_last_hs = hs;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      cmp("s_tready", 32'(s_tready), 32'(m_tready()));
      cmp("awready", 32'(awready), 32'(awvalid && wvalid && !m_bvalid));
      cmp("wready", 32'(wready), 32'(awvalid && wvalid && !m_bvalid));
      cmp("arready", 32'(arready), 32'(!m_rvalid));
      cmp("irq", 32'(irq), 32'(m_irq));
      cmp("bvalid", 32'(bvalid), 32'(m_bvalid));
      cmp("rvalid", 32'(rvalid), 32'(m_rvalid));
      if (m_bvalid) cmp("bresp", 32'(bresp), 32'(m_bresp));
      if (m_rvalid) begin
        cmp("rdata", rdata, m_rdata);
        cmp("rresp", 32'(rresp), 32'(m_rresp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    bit got = 0;
    araddr = a; arvalid = 1; rready = 1;
    tick();
    arvalid = 0;
    for (int i = 0; i < 10; i++) begin
      if (rvalid) begin got = 1; break; end
      tick();
    end
    d = rdata; r = rresp;
    if (!got) cmp("rd_timeout", 32'(0), 32'(1));
    tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, output logic [1:0] r);
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    tick();
    awvalid = 0; wvalid = 0;
    cmp("wr_bvalid", 32'(bvalid), 32'(1));
    r = bresp;
    tick();
  endtask

  task automatic push_flit(input logic [31:0] d, input logic l);
    bit ok = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1;
    for (int k = 0; k < 100; k++) begin
      if (s_tready) begin tick(); ok = 1; break; end
      tick();
    end
    s_tvalid = 0;
    if (!ok) cmp("push_timeout", 32'(0), 32'(1));
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  logic [4:0]  rd_tab [8] = '{5'h00, 5'h04, 5'h04, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14};
  logic [4:0]  wr_tab [4] = '{5'h0C, 5'h0C, 5'h10, 5'h14};

  initial begin
    int rem;
    bit have;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    cmp("rst_s_tready", 32'(s_tready), 0);
    cmp("rst_arready", 32'(arready), 0);
    cmp("rst_valids", 32'({bvalid, rvalid, irq}), 0);
    cmp("rst_rdata", rdata, 0);
    cmp("rst_resps", 32'({bresp, rresp}), 0);
    rst = 0;
    chk_en = 1;
    rd(5'h00, d, r); cmp("status_reset", d, 32'h0000_0001);
    rd(5'h0C, d, r); cmp("ctrl_reset", d, 32'h0000_0001);

    // 3-flit packet addressed here
    push_flit(32'h0000_1234, 0); push_flit(32'hA, 0); push_flit(32'hB, 1);
    rd(5'h00, d, r); cmp("status_3flit", d, 32'h0001_0304);
    rd(5'h04, d, r); cmp("data0", d, 32'h1234);
    rd(5'h04, d, r); cmp("data1", d, 32'hA);
    rd(5'h08, d, r); cmp("last_head", d, 32'h1);
    rd(5'h04, d, r); cmp("data2", d, 32'hB);
    rd(5'h00, d, r); cmp("status_drained", d, 32'h0000_0001);

    // Packet for another node is discarded without backpressure
    s_tvalid = 1; #1; cmp("drop_tready_hdr", 32'(s_tready), 1); s_tvalid = 0;
    push_flit(32'h0010_0000, 0);
    s_tvalid = 1; #1; cmp("drop_tready_body", 32'(s_tready), 1); s_tvalid = 0;
    push_flit(32'h1, 0); push_flit(32'h2, 1);
    rd(5'h00, d, r); cmp("status_after_drop", d, 32'h0000_0001);
    rd(5'h10, d, r); cmp("drop_cnt1", d, 32'h1);
    wr(5'h10, 32'h0, r); cmp("drop_clr_bresp", 32'(r), 0);
    rd(5'h10, d, r); cmp("drop_cnt_clr", d, 32'h0);

    // Fill FIFO with single-flit packets, then pop while stalled
    for (int i = 1; i <= 16; i++) push_flit(32'(i), 1);
    s_tdata = 32'd17; s_tlast = 1; s_tvalid = 1; #1;
    cmp("full_tready", 32'(s_tready), 0);
    rd(5'h00, d, r); cmp("status_full", d, 32'h0010_1006);
    araddr = 5'h04; arvalid = 1; #1;
    cmp("pop_admits", 32'(s_tready), 1);
    tick();
    arvalid = 0; s_tvalid = 0;
    cmp("pop_full_data", rdata, 32'd1);
    tick();
    rd(5'h00, d, r); cmp("status_still_full", d, 32'h0010_1006);
    for (int i = 2; i <= 17; i++) begin
      rd(5'h04, d, r); cmp("drain", d, 32'(i));
    end

    // Interrupt follows pkt_cnt by one cycle
    push_flit(32'h55, 1);
    cmp("irq_off", 32'(irq), 0);
    wr(5'h0C, 32'h3, r);
    cmp("irq_on", 32'(irq), 1);
    rd(5'h04, d, r); cmp("irq_pop_data", d, 32'h55);
    cmp("irq_cleared", 32'(irq), 0);

    // Error responses and read hold
    rd(5'h04, d, r); cmp("empty_rdata", d, 0); cmp("empty_rresp", 32'(r), 32'h2);
    rd(5'h14, d, r); cmp("bad_rd_rresp", 32'(r), 32'h2);
    wr(5'h14, 32'h1, r); cmp("bad_wr_bresp", 32'(r), 32'h2);
    araddr = 5'h00; arvalid = 1; rready = 0;
    tick();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("hold_rvalid", 32'(rvalid), 1);
      cmp("hold_rdata", rdata, 32'h0000_0001);
    end
    rready = 1; tick();
    cmp("hold_release", 32'(rvalid), 0);

    // Flush mid-packet
    push_flit(32'h0000_0001, 0); push_flit(32'h2, 0);
    wr(5'h0C, 32'h5, r);
    rd(5'h00, d, r); cmp("flush_status", d, 32'h0000_0001);
    push_flit(32'h3, 0); push_flit(32'h4, 1);
    rd(5'h00, d, r); cmp("flush_discard", d, 32'h0000_0001);
    rd(5'h10, d, r); cmp("flush_drop", d, 32'h1);
    push_flit(32'h7, 1);
    rd(5'h00, d, r); cmp("flush_next_status", d, 32'h0001_0104);
    rd(5'h04, d, r); cmp("flush_next_data", d, 32'h7);

    // Random traffic against the model
    rem = 0; have = 0;
    for (int c = 0; c < 4000; c++) begin
      if (m_last_hs) have = 0;
      if (!have) begin
        if (rem == 0) begin
          rem = $urandom_range(1, 4);
          s_tdata = $urandom();
          s_tdata[23:16] = ($urandom_range(0, 3) != 0) ? 8'h00 : 8'(($urandom_range(1, 15) << 4) | $urandom_range(0, 15));
        end else s_tdata = $urandom();
        s_tlast = (rem == 1);
        rem--;
        have = 1;
      end
      s_tvalid = have && ($urandom_range(0, 3) != 0);
      awvalid = ($urandom_range(0, 15) == 0);
      wvalid = awvalid;
      awaddr = wr_tab[$urandom_range(0, 3)];
      wdata = {29'h0, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0)};
      wstrb = 4'($urandom_range(0, 15)) | {3'b0, ($urandom_range(0, 3) != 0)};
      bready = ($urandom_range(0, 3) != 0);
      arvalid = ($urandom_range(0, 2) == 0);
      araddr = rd_tab[$urandom_range(0, 7)];
      rready = ($urandom_range(0, 3) != 0);
      tick();
    end
    s_tvalid = 0; awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (2) tick();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
